// File: rtl/vpu_pkg.sv
`default_nettype none
// vpu_pkg: instruction format, opcode set and opcode classification helpers
// shared by the request frontend, the execution controller and the ALU.
package vpu_pkg;

  localparam int STREAM_ID_WIDTH = 4;
  localparam int OPCODE_WIDTH    = 4;
  localparam int VREG_WIDTH      = 5;

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD     = 4'd0;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB     = 4'd1;
  localparam logic [OPCODE_WIDTH-1:0] OP_MUL     = 4'd2;
  localparam logic [OPCODE_WIDTH-1:0] OP_RED_SUM = 4'd3;
  localparam logic [OPCODE_WIDTH-1:0] OP_RED_MAX = 4'd4;
  localparam logic [OPCODE_WIDTH-1:0] OP_RED_MIN = 4'd5;

  typedef struct packed {
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [VREG_WIDTH-1:0]   vd;
    logic [VREG_WIDTH-1:0]   vs1;
    logic [VREG_WIDTH-1:0]   vs2;
  } vpu_h2d_req_instr_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OFFER = 2'd1,
    S_BUSY  = 2'd2
  } frontend_state_e;

  function automatic logic is_legal_op(input logic [OPCODE_WIDTH-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_RED_SUM, OP_RED_MAX, OP_RED_MIN: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_sum_op(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OP_ADD) || (op == OP_RED_SUM);
  endfunction

  function automatic logic is_reduction_op(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OP_RED_SUM) || (op == OP_RED_MAX) || (op == OP_RED_MIN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vpu_req_fifo.sv
`default_nettype none
// vpu_req_fifo: synchronous FIFO with extra-MSB pointers; no bypass path, so
// a freshly pushed entry is visible on dout one cycle after the push.
module vpu_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: empty/full come from the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/vpu_request_frontend.sv
`default_nettype none
// vpu_request_frontend: buffers host requests, drops illegal opcodes and offers
// one decoded instruction at a time to the execution controller.
module vpu_request_frontend
  import vpu_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  vpu_h2d_req_instr_t         req_instr_i,
  input  logic [STREAM_ID_WIDTH-1:0] req_stream_id_i,
  output logic                       ctrl_valid_o,
  input  logic                       ctrl_ready_i,
  output vpu_h2d_req_instr_t         instr_latch_o,
  output logic                       is_sum_o,
  output logic                       is_reduction_o,
  output logic [STREAM_ID_WIDTH-1:0] stream_id_o,
  input  logic                       resp_done_i,
  output logic                       err_illegal_o,
  output logic [ERR_CNT_WIDTH-1:0]   err_cnt_o
);

  localparam int ENTRY_W = $bits(vpu_h2d_req_instr_t) + STREAM_ID_WIDTH;

  frontend_state_e              state;
  frontend_state_e              state_next;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic                         fifo_pop;
  logic [ENTRY_W-1:0]           fifo_din;
  logic [ENTRY_W-1:0]           fifo_dout;
  vpu_h2d_req_instr_t           head_instr;
  logic [STREAM_ID_WIDTH-1:0]   head_sid;
  logic                         load_latch;
  logic                         drop_illegal;

  assign fifo_din               = {req_instr_i, req_stream_id_i};
  assign {head_instr, head_sid} = fifo_dout;
  assign req_ready_o            = !fifo_full;
  assign ctrl_valid_o           = (state == S_OFFER);

  vpu_req_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_valid_i),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_next   = state;
    fifo_pop     = 1'b0;
    load_latch   = 1'b0;
    drop_illegal = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (is_legal_op(head_instr.opcode)) begin
            load_latch = 1'b1;
            state_next = S_OFFER;
          end else begin
            drop_illegal = 1'b1;
          end
        end
      end
      S_OFFER: if (ctrl_ready_i) state_next = S_BUSY;
      S_BUSY:  if (resp_done_i)  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Dropped illegal entries never touch the latch, so it keeps the last
  // dispatched instruction while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_latch_o  <= '0;
      stream_id_o    <= '0;
      is_sum_o       <= 1'b0;
      is_reduction_o <= 1'b0;
    end else if (load_latch) begin
      instr_latch_o  <= head_instr;
      stream_id_o    <= head_sid;
      is_sum_o       <= is_sum_op(head_instr.opcode);
      is_reduction_o <= is_reduction_op(head_instr.opcode);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_illegal_o <= 1'b0;
      err_cnt_o     <= '0;
    end else begin
      err_illegal_o <= drop_illegal;
      if (drop_illegal && (err_cnt_o != '1)) begin
        err_cnt_o <= err_cnt_o + ERR_CNT_WIDTH'(1);
      end
    end
  end

endmodule
`default_nettype wire
